// File: rtl/intc_vectored.sv
// ============================================================================
// intc_vectored
//   Vectored interrupt controller for the multicycle MIPS core. Captures
//   NUM_IRQ maskable lines plus one NMI, applies per-line masking and fixed
//   priority (bit 0 highest), and hands one latched vector to the control FSM
//   at instruction boundaries through an IntReq/IntAck handshake. Tracks the
//   in-service maskable line until end-of-interrupt and allows one level of
//   NMI nesting on top of a maskable service.
//
//   Build option: define INTC_LEVEL_EN for level-sensitive maskable lines
//   (Pending follows the registered Irq sample and is not cleared by IntAck).
//   Default is rising-edge capture. Nmi is edge-sensitive in both builds.
//
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module intc_vectored #(
   parameter int unsigned      NUM_IRQ  = 4,
   parameter int unsigned      VEC_W    = 8,
   parameter logic [VEC_W-1:0] BASE_VEC = 'h20,
   parameter logic [VEC_W-1:0] NMI_VEC  = 'h02
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic               nmi_i,
   input  logic               int_enable_i,
   input  logic               mask_wr_i,
   input  logic [NUM_IRQ-1:0] mask_data_i,
   input  logic               boundary_i,
   input  logic               int_ack_i,
   input  logic               eoi_i,
   output logic               int_req_o,
   output logic [VEC_W-1:0]   int_vec_o,
   output logic               int_is_nmi_o,
   output logic [NUM_IRQ-1:0] pending_o,
   output logic [NUM_IRQ-1:0] in_service_o
);

   localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SVC     = 2'd2,
      S_NMI_SVC = 2'd3
   } state_t;

   state_t             state_q;
   logic               nested_q;
   logic [IDX_W-1:0]   win_q;
   logic               int_req_q;
   logic [VEC_W-1:0]   int_vec_q;
   logic               int_is_nmi_q;
   logic [NUM_IRQ-1:0] in_service_q;

   logic [NUM_IRQ-1:0] irq_q;
   logic               nmi_q;
   logic [NUM_IRQ-1:0] mask_q;
   logic [NUM_IRQ-1:0] pending_q;
   logic [NUM_IRQ-1:0] pending_d;
   logic               nmi_pend_q;
   logic               nmi_pend_d;

   logic               ack_take;
   logic               nmi_rise;
   logic [NUM_IRQ-1:0] eligible;
   logic [IDX_W-1:0]   sel_idx;
   logic [VEC_W-1:0]   sel_vec;
   logic [NUM_IRQ-1:0] win_onehot;

   // The handshake only completes while a request is actually outstanding.
   assign ack_take = (state_q == S_REQ) && int_ack_i;
   assign nmi_rise = nmi_i & ~nmi_q;
   assign eligible = int_enable_i ? (pending_q & ~mask_q) : '0;
   assign sel_vec  = BASE_VEC + VEC_W'(sel_idx);

   // Fixed priority: lowest eligible index wins, so scan from the top down.
   always_comb begin
      sel_idx = '0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (eligible[i]) sel_idx = IDX_W'(i);
      end
   end

   // One-hot decode of the line latched for the current request.
   always_comb begin
      win_onehot = '0;
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
         win_onehot[i] = (win_q == IDX_W'(i));
      end
   end

`ifdef INTC_LEVEL_EN
   // Level mode: Pending is simply the registered line state.
   assign pending_d = irq_q;
`else
   logic [NUM_IRQ-1:0] irq_rise;
   assign irq_rise  = irq_i & ~irq_q;
   // Edge mode: a new edge sets the bit even in the cycle it is being acked.
   assign pending_d = (pending_q & ~((ack_take && !int_is_nmi_q) ? win_onehot : '0))
                    | irq_rise;
`endif

   // NMI latch: cleared by the acknowledge of an NMI request, set wins.
   assign nmi_pend_d = (nmi_pend_q & ~(ack_take && int_is_nmi_q)) | nmi_rise;

   // Input sampling, event capture and the mask register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q      <= '0;
         nmi_q      <= 1'b0;
         pending_q  <= '0;
         nmi_pend_q <= 1'b0;
         mask_q     <= '1;
      end else begin
         irq_q      <= irq_i;
         nmi_q      <= nmi_i;
         pending_q  <= pending_d;
         nmi_pend_q <= nmi_pend_d;
         if (mask_wr_i) mask_q <= mask_data_i;
      end
   end

   // Request/service sequencer with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         nested_q     <= 1'b0;
         win_q        <= '0;
         int_req_q    <= 1'b0;
         int_vec_q    <= '0;
         int_is_nmi_q <= 1'b0;
         in_service_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (boundary_i && nmi_pend_q) begin
                  state_q      <= S_REQ;
                  int_req_q    <= 1'b1;
                  int_vec_q    <= NMI_VEC;
                  int_is_nmi_q <= 1'b1;
               end else if (boundary_i && (|eligible)) begin
                  state_q      <= S_REQ;
                  int_req_q    <= 1'b1;
                  int_vec_q    <= sel_vec;
                  int_is_nmi_q <= 1'b0;
                  win_q        <= sel_idx;
               end
            end
            S_REQ: begin
               if (int_ack_i) begin
                  int_req_q <= 1'b0;
                  if (int_is_nmi_q) begin
                     state_q <= S_NMI_SVC;
                  end else begin
                     state_q      <= S_SVC;
                     in_service_q <= win_onehot;
                  end
               end
            end
            S_SVC: begin
               if (eoi_i) begin
                  state_q      <= S_IDLE;
                  in_service_q <= '0;
               end else if (boundary_i && nmi_pend_q) begin
                  state_q      <= S_REQ;
                  nested_q     <= 1'b1;
                  int_req_q    <= 1'b1;
                  int_vec_q    <= NMI_VEC;
                  int_is_nmi_q <= 1'b1;
               end
            end
            S_NMI_SVC: begin
               if (eoi_i) begin
                  int_is_nmi_q <= 1'b0;
                  nested_q     <= 1'b0;
                  state_q      <= nested_q ? S_SVC : S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign int_req_o    = int_req_q;
   assign int_vec_o    = int_vec_q;
   assign int_is_nmi_o = int_is_nmi_q;
   assign pending_o    = pending_q;
   assign in_service_o = in_service_q;

endmodule

`default_nettype wire
